cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/rv32i_types.sv | 16 +
 rtl/cache_arbiter.sv | 123 ++++++++++++
 tb/tb_cache_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the memory hierarchy.
//   llc_cacheline - one last-level cacheline (256 bits)
//   arb_state_t   - cache_arbiter FSM states
package rv32i_types;

  localparam int unsigned LLC_LINE_BITS = 256;

  typedef logic [LLC_LINE_BITS-1:0] llc_cacheline;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cacheline-adaptor port between the instruction
// cache (read-only miss port) and the data cache (miss/writeback port).
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   i_pmem_read/address               I-cache request
//   i_pmem_rdata/resp                 I-cache response
//   d_pmem_read/write/address/wdata   D-cache request
//   d_pmem_rdata/resp                 D-cache response
//   pmem_read/write/address/wdata     shared adaptor request
//   pmem_rdata/resp                   shared adaptor response
//
// Configuration
//   CACHE_ARB_RR_EN  defined: simultaneous requests alternate (the side not
//                    granted last wins). Undefined: D always wins ties.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned s_line = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state, next_state;
  logic       d_req;

`ifdef CACHE_ARB_RR_EN
  logic       last_grant_d;
`endif

  assign d_req = d_pmem_read | d_pmem_write;

  // Read data is broadcast; resp alone qualifies it.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef CACHE_ARB_RR_EN
      last_grant_d <= 1'b0;
`endif
    end else begin
      state <= next_state;
`ifdef CACHE_ARB_RR_EN
      if (state == IDLE && next_state != IDLE)
        last_grant_d <= (next_state == SERVE_D);
`endif
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (i_pmem_read && d_req) begin
`ifdef CACHE_ARB_RR_EN
          next_state = last_grant_d ? SERVE_I : SERVE_D;
`else
          next_state = SERVE_D;
`endif
        end else if (i_pmem_read) begin
          next_state = SERVE_I;
        end else if (d_req) begin
          next_state = SERVE_D;
        end else begin
          next_state = IDLE;
        end
      end
      // A requester dropping its strobe does not abort; only resp ends a grant.
      SERVE_I: if (pmem_resp) next_state = IDLE;
      SERVE_D: if (pmem_resp) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state)
      IDLE: ;
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      SERVE_D: begin
        // Read+write together is illegal; the write takes the port.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed-vector bench for cache_arbiter.
module tb_cache_arbiter;

  localparam int unsigned LW = 256;

`ifdef CACHE_ARB_RR_EN
  localparam bit TIE_D_FIRST = 1'b0;  // prior grant was D, so I goes first
`else
  localparam bit TIE_D_FIRST = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_pmem_read = 1'b0;
  logic [31:0]   i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [31:0]   d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int unsigned checks = 0;
  int unsigned failures = 0;

  cache_arbiter #(.s_line(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".rd"},   LW'(pmem_read), '0);
    check({tag, ".wr"},   LW'(pmem_write), '0);
    check({tag, ".addr"}, LW'(pmem_address), '0);
    check({tag, ".wd"},   pmem_wdata, '0);
    check({tag, ".iresp"}, LW'(i_pmem_resp), '0);
    check({tag, ".dresp"}, LW'(d_pmem_resp), '0);
  endtask

  logic [LW-1:0] pat_a5, pat_w, pat_r;
  int unsigned   resp_cnt;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w  = {8{32'h1234_5678}};
    pat_r  = {4{64'hDEAD_BEEF_0BAD_F00D}};

    tick(); tick();
    rst = 1'b0;
    check_idle("reset");

    // Read data broadcast regardless of state
    pmem_rdata = pat_r;
    #1;
    check("bcast.i", i_pmem_rdata, pat_r);
    check("bcast.d", d_pmem_rdata, pat_r);

    // I read alone, resp after 5 cycles
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
    #1;
    check("iread.pre", LW'(pmem_read), '0);
    tick();
    check("iread.rd",   LW'(pmem_read), 1);
    check("iread.addr", LW'(pmem_address), LW'(32'h60));
    check("iread.wr",   LW'(pmem_write), '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("iread.wait_iresp", LW'(i_pmem_resp), '0);
    end
    pmem_resp = 1'b1; pmem_rdata = pat_a5;
    #1;
    check("iread.iresp", LW'(i_pmem_resp), 1);
    check("iread.data",  i_pmem_rdata, pat_a5);
    check("iread.dresp", LW'(d_pmem_resp), '0);
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    #1;
    check_idle("iread.done");

    // D write
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = pat_w;
    tick();
    check("dwr.wr",   LW'(pmem_write), 1);
    check("dwr.rd",   LW'(pmem_read), '0);
    check("dwr.addr", LW'(pmem_address), LW'(32'h1000));
    check("dwr.wd",   pmem_wdata, pat_w);
    check("dwr.pre_resp", LW'(d_pmem_resp), '0);
    tick();
    pmem_resp = 1'b1;
    #1;
    check("dwr.dresp", LW'(d_pmem_resp), 1);
    check("dwr.iresp", LW'(i_pmem_resp), '0);
    tick();
    pmem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    #1;
    check_idle("dwr.done");

    // Simultaneous I and D reads
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0200;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0400;
    tick();
    check("tie.first", LW'(pmem_address), TIE_D_FIRST ? LW'(32'h400) : LW'(32'h200));
    check("tie.first_rd", LW'(pmem_read), 1);
    pmem_resp = 1'b1;
    #1;
    check("tie.first_dresp", LW'(d_pmem_resp), LW'(TIE_D_FIRST));
    check("tie.first_iresp", LW'(i_pmem_resp), LW'(!TIE_D_FIRST));
    tick();
    pmem_resp = 1'b0;
    if (TIE_D_FIRST) d_pmem_read = 1'b0; else i_pmem_read = 1'b0;
    #1;
    check("tie.bubble", LW'(pmem_read), '0);
    tick();
    check("tie.second", LW'(pmem_address), TIE_D_FIRST ? LW'(32'h200) : LW'(32'h400));
    pmem_resp = 1'b1;
    #1;
    check("tie.second_dresp", LW'(d_pmem_resp), LW'(!TIE_D_FIRST));
    check("tie.second_iresp", LW'(i_pmem_resp), LW'(TIE_D_FIRST));
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    #1;
    check_idle("tie.done");

    // Reset in the middle of a D transaction
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0800;
    tick();
    check("rstmid.rd", LW'(pmem_read), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; d_pmem_read = 1'b0;
    #1;
    check_idle("rstmid");
    // Stray resp in IDLE
    pmem_resp = 1'b1;
    #1;
    check("stray.dresp", LW'(d_pmem_resp), '0);
    check("stray.iresp", LW'(i_pmem_resp), '0);
    tick();
    check("stray.stay_idle", LW'(pmem_read | pmem_write), '0);
    pmem_resp = 1'b0;

    // After reset the last grant is I, so a tie goes to D in either build
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0300;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0500;
    tick();
    check("rsttie.addr", LW'(pmem_address), LW'(32'h500));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    #1;

    // Requester drops strobe before resp: grant held
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0900;
    tick();
    d_pmem_read = 1'b0; i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0A00;
    tick();
    check("noabort.addr", LW'(pmem_address), LW'(32'h900));
    check("noabort.rd",   LW'(pmem_read), '0);
    pmem_resp = 1'b1;
    #1;
    check("noabort.dresp", LW'(d_pmem_resp), 1);
    check("noabort.iresp", LW'(i_pmem_resp), '0);
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    #1;

    // Illegal read+write: write wins
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0C00;
    d_pmem_wdata = pat_a5;
    tick();
    check("rw.wr", LW'(pmem_write), 1);
    check("rw.rd", LW'(pmem_read), '0);
    check("rw.wd", pmem_wdata, pat_a5);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    #1;

    // Ten back-to-back D reads, one resp each
    d_pmem_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_pmem_address = 32'h0000_2000 + 32'(i) * 32'h20;
      tick();
      check("b2b.addr", LW'(pmem_address), LW'(32'h0000_2000 + 32'(i) * 32'h20));
      resp_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        if (d_pmem_resp) resp_cnt++;
        tick();
      end
      pmem_resp = 1'b1;
      #1;
      if (d_pmem_resp) resp_cnt++;
      tick();
      pmem_resp = 1'b0;
      #1;
      if (d_pmem_resp) resp_cnt++;
      check("b2b.resp_cnt", LW'(resp_cnt), LW'(1));
    end
    d_pmem_read = 1'b0;
    tick();
    check_idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
